// File: rtl/conv11_input_pp_if.sv
// Channel-serial sample input and pixel-parallel output bundle for conv11_input_pp.
// The master drives samples and pops; the slave (the ping-pong buffer) reports readiness and pixels.
interface conv11_input_pp_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned CW         = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
);
  logic                         input_valid;
  logic [DATA_WIDTH-1:0]        data_in;
  logic                         input_ready;
  logic                         out_valid;
  logic [CH_NUM*DATA_WIDTH-1:0] out_data;
  logic                         inputbuf_read_en;
  logic [CW-1:0]                ch_idx;

  modport master (
    output input_valid, data_in, inputbuf_read_en,
    input  input_ready, out_valid, out_data, ch_idx
  );

  modport slave (
    input  input_valid, data_in, inputbuf_read_en,
    output input_ready, out_valid, out_data, ch_idx
  );
endinterface

// File: rtl/conv11_input_pp.sv
// Two-bank ping-pong pixel assembler: collects CH_NUM channel-serial samples into one
// pixel per bank and presents completed pixels in arrival order.
module conv11_input_pp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned CW         = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  conv11_input_pp_if.slave      bus
);

  localparam int unsigned PW      = CH_NUM * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_CH = CW'(CH_NUM - 1);

  logic [DATA_WIDTH-1:0] r_bank [2][CH_NUM];
  logic [1:0]            r_full;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [CW-1:0]         r_ch_idx;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_pop;
  logic [1:0]            w_full_nxt;
  logic [PW-1:0]         w_out_data;

  assign w_ready  = ~r_full[r_wr_ptr];
  assign w_accept = bus.input_valid & w_ready;
  assign w_last   = (r_ch_idx == LAST_CH);
  assign w_pop    = bus.inputbuf_read_en & r_full[r_rd_ptr];

  // Completion and pop always target different banks, so both can apply together.
  always_comb begin
    w_full_nxt = r_full;
    if (w_pop)
      w_full_nxt[r_rd_ptr] = 1'b0;
    if (w_accept && w_last)
      w_full_nxt[r_wr_ptr] = 1'b1;
  end

  always_comb begin
    w_out_data = '0;
    for (int k = 0; k < int'(CH_NUM); k++)
      w_out_data[k*DATA_WIDTH +: DATA_WIDTH] = r_bank[r_rd_ptr][k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_ch_idx <= '0;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < int'(CH_NUM); k++)
          r_bank[b][k] <= '0;
    end else if (clear) begin
      r_full   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_ch_idx <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      if (w_accept) begin
        r_bank[r_wr_ptr][r_ch_idx] <= bus.data_in;
        if (w_last) begin
          r_ch_idx <= '0;
          r_wr_ptr <= ~r_wr_ptr;
        end else begin
          r_ch_idx <= r_ch_idx + CW'(1);
        end
      end
    end
  end

  assign bus.input_ready = w_ready;
  assign bus.out_valid   = r_full[r_rd_ptr];
  assign bus.out_data    = w_out_data;
  assign bus.ch_idx      = r_ch_idx;

endmodule

// File: tb/tb_conv11_input_pp.sv
// Bench for conv11_input_pp at CH_NUM=4 and CH_NUM=1 against a queue-based pixel model.
module tb_conv11_input_pp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s [2];
  logic       clr_s [2];
  logic       vin   [2];
  logic       rde   [2];
  logic [7:0] din   [2];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  conv11_input_pp_if #(.DATA_WIDTH(8), .CH_NUM(4)) if4 ();
  conv11_input_pp_if #(.DATA_WIDTH(8), .CH_NUM(1)) if1 ();

  assign if4.input_valid      = vin[0];
  assign if4.data_in          = din[0];
  assign if4.inputbuf_read_en = rde[0];
  assign if1.input_valid      = vin[1];
  assign if1.data_in          = din[1];
  assign if1.inputbuf_read_en = rde[1];

  conv11_input_pp #(.DATA_WIDTH(8), .CH_NUM(4)) u_dut4 (
    .clk(clk), .rst(rst_s[0]), .clear(clr_s[0]), .bus(if4.slave)
  );
  conv11_input_pp #(.DATA_WIDTH(8), .CH_NUM(1)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .clear(clr_s[1]), .bus(if1.slave)
  );

  logic        d_rdy  [2];
  logic        d_val  [2];
  logic [31:0] d_data [2];
  logic [31:0] d_ch   [2];

  assign d_rdy[0]  = if4.input_ready;
  assign d_val[0]  = if4.out_valid;
  assign d_data[0] = if4.out_data;
  assign d_ch[0]   = 32'(if4.ch_idx);
  assign d_rdy[1]  = if1.input_ready;
  assign d_val[1]  = if1.out_valid;
  assign d_data[1] = 32'(if1.out_data);
  assign d_ch[1]   = 32'(if1.ch_idx);

  // Model: FIFO of completed pixels (depth 2) plus the partially assembled pixel.
  logic [31:0] mq    [2][$];
  logic [31:0] mpart [2];
  int          mpc   [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare against the model, then advance it with the inputs the next edge will sample.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int  nch;
      bit  acc;
      bit  pop;
      nch = (d == 0) ? 4 : 1;
      if (chk_en) begin
        chk($sformatf("ready%0d", d), 32'(d_rdy[d]), 32'(mq[d].size() < 2));
        chk($sformatf("valid%0d", d), 32'(d_val[d]), 32'(mq[d].size() > 0));
        chk($sformatf("ch_idx%0d", d), d_ch[d], 32'(mpc[d]));
        if (mq[d].size() > 0)
          chk($sformatf("data%0d", d), d_data[d], mq[d][0]);
      end
      if (rst_s[d] === 1'b1 || clr_s[d] === 1'b1) begin
        mq[d].delete();
        mpart[d] = '0;
        mpc[d]   = 0;
      end else begin
        acc = (vin[d] === 1'b1) && (mq[d].size() < 2);
        pop = (rde[d] === 1'b1) && (mq[d].size() > 0);
        if (pop)
          void'(mq[d].pop_front());
        if (acc) begin
          mpart[d][mpc[d]*8 +: 8] = din[d];
          mpc[d]++;
          if (mpc[d] == nch) begin
            mq[d].push_back(mpart[d]);
            mpart[d] = '0;
            mpc[d]   = 0;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [7:0] v);
    vin[d] = 1'b1;
    din[d] = v;
    cyc();
    vin[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    vin[d]   = 1'b0;
    rde[d]   = 1'b0;
    clr_s[d] = 1'b0;
    rst_s[d] = 1'b1;
    cyc();
    rst_s[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; clr_s[d] = 1'b0; vin[d] = 1'b0; rde[d] = 1'b0; din[d] = '0;
      mpart[d] = '0; mpc[d] = 0;
    end
    cyc();
    cyc();
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    chk_en = 1'b1;

    chk("rst_ready", 32'(d_rdy[0]), 32'd1);
    chk("rst_valid", 32'(d_val[0]), 32'd0);
    chk("rst_data", d_data[0], 32'h0);
    chk("rst_ch", d_ch[0], 32'd0);

    // Single pixel, no pops.
    send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
    chk("single_v3", 32'(d_val[0]), 32'd0);
    chk("single_ch3", d_ch[0], 32'd3);
    send(0, 8'h44);
    chk("single_valid", 32'(d_val[0]), 32'd1);
    chk("single_data", d_data[0], 32'h44332211);
    chk("single_ch", d_ch[0], 32'd0);

    // Backpressure with both banks full, then one pop.
    do_reset(0);
    for (int i = 1; i <= 8; i++) send(0, 8'(i));
    chk("bp_ready", 32'(d_rdy[0]), 32'd0);
    vin[0] = 1'b1; din[0] = 8'h09;
    cyc(); cyc();
    chk("bp_hold_ch", d_ch[0], 32'd0);
    chk("bp_px1", d_data[0], 32'h04030201);
    rde[0] = 1'b1;
    cyc();
    rde[0] = 1'b0;
    chk("bp_ready_back", 32'(d_rdy[0]), 32'd1);
    chk("bp_px2", d_data[0], 32'h08070605);
    chk("bp_ch_nostall", d_ch[0], 32'd0);
    cyc();
    vin[0] = 1'b0;
    chk("bp_9th_acc", d_ch[0], 32'd1);

    // Completion into one bank while the other bank pops.
    do_reset(0);
    for (int i = 1; i <= 7; i++) send(0, 8'(8'h20 + i));
    rde[0] = 1'b1;
    send(0, 8'h28);
    rde[0] = 1'b0;
    chk("conc_valid", 32'(d_val[0]), 32'd1);
    chk("conc_ready", 32'(d_ready_wrap(0)), 32'd1);
    chk("conc_data", d_data[0], 32'h28272625);

    // Streaming with pops every cycle on both instances.
    do_reset(0);
    do_reset(1);
    rde[0] = 1'b1; rde[1] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      vin[0] = 1'b1; din[0] = 8'($urandom);
      vin[1] = 1'b1; din[1] = 8'($urandom);
      cyc();
      chk("stream_ready4", 32'(d_rdy[0]), 32'd1);
      chk("stream_ready1", 32'(d_rdy[1]), 32'd1);
    end
    vin[0] = 1'b0; vin[1] = 1'b0; rde[0] = 1'b0; rde[1] = 1'b0;
    cyc(); cyc();

    // Clear mid-pixel with one pixel buffered.
    do_reset(0);
    send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
    send(0, 8'h55); send(0, 8'h66);
    vin[0] = 1'b1; din[0] = 8'h77; clr_s[0] = 1'b1; rde[0] = 1'b1;
    cyc();
    vin[0] = 1'b0; clr_s[0] = 1'b0; rde[0] = 1'b0;
    chk("clr_valid", 32'(d_val[0]), 32'd0);
    chk("clr_ch", d_ch[0], 32'd0);
    chk("clr_ready", 32'(d_rdy[0]), 32'd1);
    send(0, 8'hA1); send(0, 8'hA2); send(0, 8'hA3); send(0, 8'hA4);
    chk("clr_fresh", d_data[0], 32'hA4A3A2A1);

    // Reset with both banks full, then an ignored pop.
    for (int i = 0; i < 4; i++) send(0, 8'(8'hB0 + i));
    chk("prerst_full", 32'(d_rdy[0]), 32'd0);
    do_reset(0);
    chk("mrst_valid", 32'(d_val[0]), 32'd0);
    chk("mrst_data", d_data[0], 32'h0);
    chk("mrst_ready", 32'(d_rdy[0]), 32'd1);
    rde[0] = 1'b1;
    cyc();
    rde[0] = 1'b0;
    chk("mrst_pop_valid", 32'(d_val[0]), 32'd0);
    chk("mrst_pop_ready", 32'(d_rdy[0]), 32'd1);
    chk("mrst_pop_ch", d_ch[0], 32'd0);

    // Single-channel instance: every sample is a pixel.
    do_reset(1);
    send(1, 8'h5A);
    chk("one_valid", 32'(d_val[1]), 32'd1);
    chk("one_data", d_data[1], 32'h5A);
    chk("one_ch", d_ch[1], 32'd0);
    send(1, 8'hA5);
    chk("one_full", 32'(d_rdy[1]), 32'd0);
    chk("one_order", d_data[1], 32'h5A);

    // Randomized traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        vin[d]   = ($urandom_range(0, 3) != 0);
        din[d]   = 8'($urandom);
        rde[d]   = ($urandom_range(0, 2) == 0);
        clr_s[d] = ($urandom_range(0, 63) == 0);
        rst_s[d] = ($urandom_range(0, 199) == 0);
      end
      cyc();
    end
    for (int d = 0; d < 2; d++) begin
      vin[d] = 1'b0; rde[d] = 1'b0; clr_s[d] = 1'b0; rst_s[d] = 1'b0;
    end
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic d_ready_wrap(input int d);
    return d_rdy[d];
  endfunction

endmodule
